// File: rtl/bmf_h_decoder_pkg.sv
// Shared constants and types for the BMF H-side decoder.
// Semiring selection follows the BMF_XOR_SEMIRING_EN macro (defined: GF(2) XOR, undefined: Boolean OR).
package bmf_pkg;

  localparam int K_DEF     = 1;
  localparam int M_DEF     = 3;
  localparam int CNT_W_DEF = 16;

  function automatic int row_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  typedef enum logic {SR_OR, SR_XOR} semiring_e;

`ifdef BMF_XOR_SEMIRING_EN
  localparam semiring_e SEMIRING = SR_XOR;
`else
  localparam semiring_e SEMIRING = SR_OR;
`endif

  typedef enum logic {EMPTY, FULL} ostate_e;

endpackage

// File: rtl/bmf_h_decoder_product.sv
// Combinational Boolean/GF(2) product of a latent code with a flattened basis matrix H.
// Reduction chosen by bmf_pkg::SEMIRING (BMF_XOR_SEMIRING_EN); reusable by compressor-side checkers.
module bmf_h_product
  import bmf_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int M = M_DEF
) (
  input  logic [K-1:0]   in_k,
  input  logic [K*M-1:0] h_flat,
  output logic [M-1:0]   prod
);

  always_comb begin
    prod = '0;
    for (int i = 0; i < K; i++) begin
      if (in_k[i]) begin
        if (SEMIRING == SR_XOR) prod = prod ^ h_flat[i*M +: M];
        else                    prod = prod | h_flat[i*M +: M];
      end
    end
  end

endmodule

// File: rtl/bmf_h_decoder.sv
// Streaming BMF decompressor: runtime-loadable H rows, one-register valid/ready output stage, saturating beat counter.
// Optional macro BMF_XOR_SEMIRING_EN switches the product to GF(2) (handled in bmf_pkg / bmf_h_product).
module bmf_h_decoder
  import bmf_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int M     = M_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int RW   = row_w(K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_we,
  input  logic [RW-1:0]    h_row,
  input  logic [M-1:0]     h_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_data,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [M-1:0]     h_p0 [K];
  logic [K*M-1:0]   h_flat_p0;
  logic [M-1:0]     prod_p0;
  logic [M-1:0]     out_data_p1;
  logic [CNT_W-1:0] cnt_p1;
  ostate_e          state_p1, state_nxt;
  logic             acc_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar g = 0; g < K; g++) begin : g_flat
    assign h_flat_p0[g*M +: M] = h_p0[g];
  end

  // Stage p0: product from the H rows as they stand before any same-cycle write
  bmf_h_product #(.K(K), .M(M)) u_product (
    .in_k   (in_k),
    .h_flat (h_flat_p0),
    .prod   (prod_p0)
  );

  assign in_ready = (state_p1 == EMPTY) | out_ready;
  assign acc_p0   = in_valid & in_ready;

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (acc_p0) state_nxt = FULL;
      FULL:    if (out_ready && !acc_p0) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p1: output register, counter and H storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= EMPTY;
      out_data_p1 <= '0;
      cnt_p1      <= '0;
      for (int i = 0; i < K; i++) h_p0[i] <= '1;
    end else begin
      state_p1 <= state_nxt;
      if (acc_p0) begin
        out_data_p1 <= prod_p0;
        cnt_p1      <= sat_inc(cnt_p1);
      end
      if (h_we && (int'(h_row) < K)) h_p0[h_row] <= h_data;
    end
  end

  assign out_valid = (state_p1 == FULL);
  assign out_data  = out_data_p1;
  assign beat_cnt  = cnt_p1;

endmodule

// File: tb/tb_bmf_h_decoder.sv
// Self-checking bench for bmf_h_decoder (K=3, M=3, CNT_W=4) with a queue-based reference model.
module tb_bmf_h_decoder;

  localparam int K = 3;
  localparam int M = 3;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             h_we;
  logic [1:0]       h_row;
  logic [M-1:0]     h_data;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_k;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_data;
  logic [CNT_W-1:0] beat_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [M-1:0] mh [K];
  logic [M-1:0] mq [$];
  int           mcnt;

  bmf_h_decoder #(.K(K), .M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .h_we(h_we), .h_row(h_row), .h_data(h_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] ref_prod(input logic [K-1:0] k);
    logic [M-1:0] r = '0;
    for (int i = 0; i < K; i++)
      if (k[i]) begin
`ifdef BMF_XOR_SEMIRING_EN
        r = r ^ mh[i];
`else
        r = r | mh[i];
`endif
      end
    return r;
  endfunction

  // advance one clock and apply this cycle's inputs to the model
  task automatic cyc();
    logic acc;
    acc = in_valid && ((mq.size() == 0) || out_ready);
    if (rst) begin
      mq.delete();
      for (int i = 0; i < K; i++) mh[i] = '1;
      mcnt = 0;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(ref_prod(in_k));
        if (mcnt < CMAX) mcnt++;
      end
      if (h_we && (int'(h_row) < K)) mh[h_row] = h_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_we = 0; h_row = 0; h_data = 0; in_valid = 0; in_k = 0; out_ready = 1;
  endtask

  task automatic send(input logic [K-1:0] k);
    idle(); in_valid = 1; in_k = k;
    cyc();
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    cyc(); cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 3'b000) begin bad++; $display("FAIL reset_out_data got=%b want=000", out_data); end
    total++; if (beat_cnt !== 4'd0) begin bad++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst = 0;
    cyc();
  endtask

  task automatic test_basic();
    send(3'b001);
    total++; if (out_valid !== 1'b1 || out_data !== 3'b111) begin bad++; $display("FAIL basic_ones got=%b/%b want=1/111", out_valid, out_data); end
    send(3'b000);
    total++; if (out_valid !== 1'b1 || out_data !== 3'b000) begin bad++; $display("FAIL basic_zero got=%b/%b want=1/000", out_valid, out_data); end
    total++; if (beat_cnt !== 4'd2) begin bad++; $display("FAIL basic_cnt got=%0d want=2", beat_cnt); end
  endtask

  task automatic test_product();
    logic [M-1:0] want;
    idle(); h_we = 1; h_row = 0; h_data = 3'b001; cyc();
    h_row = 1; h_data = 3'b011; cyc();
    h_we = 0;
`ifdef BMF_XOR_SEMIRING_EN
    want = 3'b010;
`else
    want = 3'b011;
`endif
    send(3'b011);
    total++; if (out_data !== want) begin bad++; $display("FAIL product_k3 got=%b want=%b", out_data, want); end
    send(3'b001);
    total++; if (out_data !== 3'b001) begin bad++; $display("FAIL product_k1 got=%b want=001", out_data); end
  endtask

  task automatic test_backpressure();
    int c0;
    idle(); cyc();
    c0 = mcnt;
    out_ready = 0; in_valid = 1; in_k = 3'b100;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin h_we = 1; h_row = 2; h_data = 3'b010; end
      else h_we = 0;
      cyc();
    end
    h_we = 0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== 3'b111) begin bad++; $display("FAIL bp_held got=%b/%b want=1/111", out_valid, out_data); end
    total++; if (int'(beat_cnt) !== c0 + 1) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", beat_cnt, c0 + 1); end
    out_ready = 1;
    in_k = 3'b001; cyc();
    total++; if (out_valid !== 1'b1 || out_data !== 3'b001) begin bad++; $display("FAIL b2b_0 got=%b/%b want=1/001", out_valid, out_data); end
    in_k = 3'b010; cyc();
    total++; if (out_valid !== 1'b1 || out_data !== 3'b011) begin bad++; $display("FAIL b2b_1 got=%b/%b want=1/011", out_valid, out_data); end
    in_k = 3'b100; cyc();
    total++; if (out_valid !== 1'b1 || out_data !== 3'b010) begin bad++; $display("FAIL b2b_2 got=%b/%b want=1/010", out_valid, out_data); end
    total++; if (int'(beat_cnt) !== c0 + 4) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", beat_cnt, c0 + 4); end
    in_valid = 0;
  endtask

  task automatic test_same_cycle();
    idle(); h_we = 1; h_row = 1; h_data = 3'b100; in_valid = 1; in_k = 3'b010;
    cyc();
    idle();
    total++; if (out_data !== 3'b011) begin bad++; $display("FAIL samecyc_old got=%b want=011", out_data); end
    send(3'b010);
    total++; if (out_data !== 3'b100) begin bad++; $display("FAIL samecyc_new got=%b want=100", out_data); end
  endtask

  task automatic test_out_of_range();
    idle(); h_we = 1; h_row = 2'd3; h_data = 3'b000; cyc();
    idle();
    send(3'b001);
    total++; if (out_data !== 3'b001) begin bad++; $display("FAIL oor_row0 got=%b want=001", out_data); end
    send(3'b010);
    total++; if (out_data !== 3'b100) begin bad++; $display("FAIL oor_row1 got=%b want=100", out_data); end
    send(3'b100);
    total++; if (out_data !== 3'b010) begin bad++; $display("FAIL oor_row2 got=%b want=010", out_data); end
  endtask

  task automatic test_mid_reset();
    idle(); out_ready = 0; in_valid = 1; in_k = 3'b001; cyc();
    idle(); out_ready = 0; rst = 1; cyc();
    total++; if (out_valid !== 1'b0 || out_data !== 3'b000) begin bad++; $display("FAIL midrst_out got=%b/%b want=0/000", out_valid, out_data); end
    total++; if (beat_cnt !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ctl got=%0d/%b want=0/1", beat_cnt, in_ready); end
    rst = 0;
    for (int i = 0; i < K; i++) begin
      send(3'(1 << i));
      total++; if (out_data !== 3'b111) begin bad++; $display("FAIL midrst_row%0d got=%b want=111", i, out_data); end
    end
  endtask

  task automatic test_saturation();
    idle(); in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_k = 3'($urandom_range(0, 7));
      cyc();
    end
    idle();
    total++; if (beat_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%h want=f", beat_cnt); end
  endtask

  task automatic test_random();
    idle(); rst = 1; cyc(); rst = 0;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_k      = 3'($urandom_range(0, 7));
      h_we      = $urandom_range(0, 4) == 0;
      h_row     = 2'($urandom_range(0, 3));
      h_data    = 3'($urandom_range(0, 7));
      #3;
      total++; if (in_ready !== ((mq.size() == 0) || out_ready)) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b want=%b", n, in_ready, (mq.size() == 0) || out_ready); end
      total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%b want=%b", n, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        total++; if (out_data !== mq[0]) begin bad++; $display("FAIL rnd_out_data n=%0d got=%b want=%b", n, out_data, mq[0]); end
      end
      total++; if (int'(beat_cnt) !== mcnt) begin bad++; $display("FAIL rnd_beat_cnt n=%0d got=%0d want=%0d", n, beat_cnt, mcnt); end
      cyc();
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < K; i++) mh[i] = '1;
    mcnt = 0;
    rst = 1;
    idle();
    test_reset();
    test_basic();
    test_product();
    test_backpressure();
    test_same_cycle();
    test_out_of_range();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
